// File: rtl/dbi_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the DBI TX path:
// the three command streams plus the monitored pixel byte handshake.
interface dbi_frame_scheduler_if #(
    parameter int DBI_IF_D_W = 8
);
    logic [DBI_IF_D_W-1:0] tx_type_o;
    logic                  tx_type_vld_o;
    logic                  tx_type_rdy_i;
    logic [DBI_IF_D_W-1:0] tx_com_o;
    logic                  tx_com_vld_o;
    logic                  tx_com_rdy_i;
    logic [DBI_IF_D_W-1:0] tx_data_o;
    logic                  tx_data_vld_o;
    logic                  tx_data_rdy_i;
    logic                  pxl_vld_i;
    logic                  pxl_rdy_i;
    logic                  pxl_stream_en_o;

    modport master (
        output tx_type_o, tx_type_vld_o,
        input  tx_type_rdy_i,
        output tx_com_o, tx_com_vld_o,
        input  tx_com_rdy_i,
        output tx_data_o, tx_data_vld_o,
        input  tx_data_rdy_i,
        input  pxl_vld_i, pxl_rdy_i,
        output pxl_stream_en_o
    );

    modport slave (
        input  tx_type_o, tx_type_vld_o,
        output tx_type_rdy_i,
        input  tx_com_o, tx_com_vld_o,
        output tx_com_rdy_i,
        input  tx_data_o, tx_data_vld_o,
        output tx_data_rdy_i,
        output pxl_vld_i, pxl_rdy_i,
        input  pxl_stream_en_o
    );
endinterface

// File: rtl/dbi_frame_scheduler.sv
// Frame sequencer for the DBI TX path: emits the 0x2A/0x2B window
// transactions, opens the pixel stream and closes it after the window's bytes.
module dbi_frame_scheduler #(
    parameter int DBI_IF_D_W    = 8,
    parameter int COORD_W       = 16,
    parameter int BYTES_PER_PXL = 2,
    parameter int BYTE_CNT_W    = 32,
    parameter int REFRESH_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   x_start_i,
    input  logic [COORD_W-1:0]   x_end_i,
    input  logic [COORD_W-1:0]   y_start_i,
    input  logic [COORD_W-1:0]   y_end_i,
    input  logic                 frame_start_i,
    input  logic                 auto_refresh_en_i,
    input  logic [REFRESH_W-1:0] refresh_period_i,
    dbi_frame_scheduler_if.master bus,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 win_err_o
);

    typedef enum logic [3:0] {
        IDLE, CALC, CA_TYPE, CA_COM, CA_DATA,
        RA_TYPE, RA_COM, RA_DATA, STREAM, DONE
    } state_t;

    localparam logic [DBI_IF_D_W-1:0] TYPE_WR4 = DBI_IF_D_W'(8'h10);
    localparam logic [DBI_IF_D_W-1:0] CMD_CASET = DBI_IF_D_W'(8'h2A);
    localparam logic [DBI_IF_D_W-1:0] CMD_RASET = DBI_IF_D_W'(8'h2B);

    state_t                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [REFRESH_W-1:0]    refresh_cnt_q, refresh_cnt_d;
    logic [COORD_W-1:0]      xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [BYTE_CNT_W-1:0]   total_q, total_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]              beat_q, beat_d;
    logic [DBI_IF_D_W-1:0]   tx_type_q, tx_type_d;
    logic                    tx_type_vld_q, tx_type_vld_d;
    logic [DBI_IF_D_W-1:0]   tx_com_q, tx_com_d;
    logic                    tx_com_vld_q, tx_com_vld_d;
    logic [DBI_IF_D_W-1:0]   tx_data_q, tx_data_d;
    logic                    tx_data_vld_q, tx_data_vld_d;
    logic                    stream_en_q, stream_en_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic                    win_err_q, win_err_d;

    logic refresh_on, refresh_tick, start_req, win_bad;
    logic type_hs, com_hs, data_hs, pxl_hs, last_beat, last_pxl;
    logic [BYTE_CNT_W-1:0] width_px, height_px;

    function automatic logic [DBI_IF_D_W-1:0] coord_byte(
        input logic [COORD_W-1:0] first,
        input logic [COORD_W-1:0] last,
        input logic [1:0]         beat
    );
        logic [DBI_IF_D_W-1:0] b;
        case (beat)
            2'd0:    b = first[COORD_W-1 -: DBI_IF_D_W];
            2'd1:    b = first[DBI_IF_D_W-1:0];
            2'd2:    b = last[COORD_W-1 -: DBI_IF_D_W];
            default: b = last[DBI_IF_D_W-1:0];
        endcase
        return b;
    endfunction

    // Truncated products are congruent mod 2^BYTE_CNT_W, so working at that width is exact.
    assign width_px  = BYTE_CNT_W'(xe_q) - BYTE_CNT_W'(xs_q) + BYTE_CNT_W'(1);
    assign height_px = BYTE_CNT_W'(ye_q) - BYTE_CNT_W'(ys_q) + BYTE_CNT_W'(1);

    assign refresh_on   = auto_refresh_en_i && (refresh_period_i != '0);
    assign refresh_tick = refresh_on && (refresh_cnt_q >= refresh_period_i - REFRESH_W'(1));
    assign start_req    = frame_start_i || refresh_tick;
    assign win_bad      = (x_end_i < x_start_i) || (y_end_i < y_start_i);

    assign type_hs   = tx_type_vld_q && bus.tx_type_rdy_i;
    assign com_hs    = tx_com_vld_q && bus.tx_com_rdy_i;
    assign data_hs   = tx_data_vld_q && bus.tx_data_rdy_i;
    assign pxl_hs    = bus.pxl_vld_i && bus.pxl_rdy_i && stream_en_q;
    assign last_beat = data_hs && (beat_q == 2'd3);
    assign last_pxl  = pxl_hs && (byte_cnt_q == total_q - BYTE_CNT_W'(1));

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        refresh_cnt_d = (!refresh_on || refresh_tick) ? '0 : refresh_cnt_q + REFRESH_W'(1);
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        total_d       = total_q;
        byte_cnt_d    = byte_cnt_q;
        beat_d        = beat_q;
        tx_type_d     = tx_type_q;
        tx_com_d      = tx_com_q;
        tx_data_d     = tx_data_q;
        tx_type_vld_d = 1'b0;
        tx_com_vld_d  = 1'b0;
        tx_data_vld_d = 1'b0;
        stream_en_d   = 1'b0;
        win_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_req || pending_q) begin
                    pending_d = 1'b0;
                    if (win_bad) begin
                        win_err_d = 1'b1;
                    end else begin
                        xs_d    = x_start_i;
                        xe_d    = x_end_i;
                        ys_d    = y_start_i;
                        ye_d    = y_end_i;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                total_d    = width_px * height_px * BYTE_CNT_W'(BYTES_PER_PXL);
                byte_cnt_d = '0;
                beat_d     = 2'd0;
                state_d    = CA_TYPE;
            end
            CA_TYPE, RA_TYPE: begin
                tx_type_d     = TYPE_WR4;
                tx_type_vld_d = !type_hs;
                if (type_hs) state_d = (state_q == CA_TYPE) ? CA_COM : RA_COM;
            end
            CA_COM, RA_COM: begin
                tx_com_d     = (state_q == CA_COM) ? CMD_CASET : CMD_RASET;
                tx_com_vld_d = !com_hs;
                if (com_hs) state_d = (state_q == CA_COM) ? CA_DATA : RA_DATA;
            end
            CA_DATA, RA_DATA: begin
                if (data_hs) beat_d = beat_q + 2'd1;
                tx_data_vld_d = !last_beat;
                if (!last_beat) begin
                    tx_data_d = (state_q == CA_DATA) ? coord_byte(xs_q, xe_q, beat_d)
                                                     : coord_byte(ys_q, ye_q, beat_d);
                end else begin
                    state_d = (state_q == CA_DATA) ? RA_TYPE : STREAM;
                end
            end
            STREAM: begin
                stream_en_d = !last_pxl;
                if (pxl_hs) byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                if (last_pxl) state_d = DONE;
            end
            DONE: begin
                byte_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only one request can wait behind the running frame.
        if (state_q != IDLE && start_req) pending_d = 1'b1;

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            refresh_cnt_q <= '0;
            xs_q          <= '0;
            xe_q          <= '0;
            ys_q          <= '0;
            ye_q          <= '0;
            total_q       <= '0;
            byte_cnt_q    <= '0;
            beat_q        <= 2'd0;
            tx_type_q     <= '0;
            tx_type_vld_q <= 1'b0;
            tx_com_q      <= '0;
            tx_com_vld_q  <= 1'b0;
            tx_data_q     <= '0;
            tx_data_vld_q <= 1'b0;
            stream_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            win_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            refresh_cnt_q <= refresh_cnt_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            total_q       <= total_d;
            byte_cnt_q    <= byte_cnt_d;
            beat_q        <= beat_d;
            tx_type_q     <= tx_type_d;
            tx_type_vld_q <= tx_type_vld_d;
            tx_com_q      <= tx_com_d;
            tx_com_vld_q  <= tx_com_vld_d;
            tx_data_q     <= tx_data_d;
            tx_data_vld_q <= tx_data_vld_d;
            stream_en_q   <= stream_en_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            win_err_q     <= win_err_d;
        end
    end

    assign bus.tx_type_o       = tx_type_q;
    assign bus.tx_type_vld_o   = tx_type_vld_q;
    assign bus.tx_com_o        = tx_com_q;
    assign bus.tx_com_vld_o    = tx_com_vld_q;
    assign bus.tx_data_o       = tx_data_q;
    assign bus.tx_data_vld_o   = tx_data_vld_q;
    assign bus.pxl_stream_en_o = stream_en_q;
    assign busy_o              = busy_q;
    assign frame_done_o        = frame_done_q;
    assign win_err_o           = win_err_q;

endmodule

// File: doc/dbi_frame_scheduler.md
Name: dbi_frame_scheduler

Overview:
- Sequences one display frame on the DBI TX path: writes the column-address-set (0x2A) and row-address-set (0x2B) transactions into the TX_TYPE/TX_COM/TX_DATA streams, then opens the pixel stream.
- Monitors the pixel handshake until the window's byte count has been transferred, then closes the stream and reports frame completion.
- Sits beside the configuration-bus FIFOs, in front of the DBI TX FSM. Frames start either on request or from an internal refresh timer.

Parameters:
DBI_IF_D_W, 8, width of tx_type/tx_com/tx_data bytes
COORD_W, 16, width of window coordinates
BYTES_PER_PXL, 2, DBI bytes per pixel (RGB565)
BYTE_CNT_W, 32, width of frame byte counter
REFRESH_W, 32, width of refresh period/timer

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
x_start_i  in  COORD_W  first column
x_end_i  in  COORD_W  last column (inclusive)
y_start_i  in  COORD_W  first row
y_end_i  in  COORD_W  last row (inclusive)
frame_start_i  in  1  single-cycle frame request
auto_refresh_en_i  in  1  enable refresh timer
refresh_period_i  in  REFRESH_W  cycles between auto frames; 0 = timer off
tx_type_o  out  DBI_IF_D_W  transaction type byte
tx_type_vld_o  out  1  type valid
tx_type_rdy_i  in  1  type ready
tx_com_o  out  DBI_IF_D_W  command byte
tx_com_vld_o  out  1  command valid
tx_com_rdy_i  in  1  command ready
tx_data_o  out  DBI_IF_D_W  parameter byte
tx_data_vld_o  out  1  data valid
tx_data_rdy_i  in  1  data ready
pxl_vld_i  in  1  monitored pixel-byte valid (DBI TX FSM input side)
pxl_rdy_i  in  1  monitored pixel-byte ready
pxl_stream_en_o  out  1  gate: pixel path may transfer
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse at frame end
win_err_o  out  1  one-cycle pulse: request rejected, bad window

Behaviour:
- Clock is clk; reset is synchronous, active-high (rst). Outputs at reset: all *_vld_o, pxl_stream_en_o, busy_o, frame_done_o and win_err_o are 0; data outputs are 0. State is IDLE, counters are 0, pending flag is 0.
- Start request = frame_start_i OR refresh tick.
- Refresh timer runs only when auto_refresh_en_i=1 and refresh_period_i!=0. It counts 0..period-1. At period-1 it produces a tick and wraps to 0. Clearing the enable resets the timer to 0.
- Start request in IDLE:
  - If x_end<x_start or y_end<y_start: pulse win_err_o next cycle and stay in IDLE.
  - Otherwise latch all four coordinates and go to CALC.
- Start request when not in IDLE sets pending (at most one is held; extra requests are dropped). Pending is serviced from IDLE the cycle after DONE.
- CALC (1 cycle): total = (x_end-x_start+1)*(y_end-y_start+1)*BYTES_PER_PXL, computed at full precision and truncated to BYTE_CNT_W. Then go to CA_TYPE.
- CA_TYPE: tx_type_o=8'h10 (rw=0, hrst=0, dat_amt=4). Hold valid until the rdy handshake.
- CA_COM: tx_com_o=8'h2A.
- CA_DATA: 4 beats, in order x_start[15:8], x_start[7:0], x_end[15:8], x_end[7:0]. A 2-bit beat counter advances on each handshake.
- RA_TYPE, RA_COM, RA_DATA: same as the CA states, with 8'h2B and the y coordinates.
- Stream handshake rules:
  - Exactly one *_vld_o is high at a time.
  - Valid is registered and asserts the cycle after entering a state.
  - Data is stable while valid=1 and rdy=0.
  - Handshake = vld&rdy; the next beat or state follows in the next cycle.
- STREAM:
  - pxl_stream_en_o=1 (registered, on the cycle after entry).
  - The byte counter increments on pxl_vld_i&pxl_rdy_i&pxl_stream_en_o.
  - On the handshake where counter==total-1: pxl_stream_en_o drops the next cycle and the state goes to DONE.
- DONE (1 cycle): frame_done_o=1, counter cleared, then IDLE.
- busy_o=1 in every state except IDLE.
- Window inputs may change freely mid-frame; only latched values are used.
- Minimum frame (1x1): total=2; DONE follows the second pixel handshake.
- Reset asserted mid-frame aborts immediately. Outputs go to reset values next edge and pending is cleared.

Test Plan:
- Window x 0..1, y 0..0, frame_start_i, all rdy=1 → type 8'h10, com 8'h2A, data 00,00,00,01; type 8'h10, com 8'h2B, data 00,00,00,00. Stream opens; frame_done_o pulses after exactly 4 pixel handshakes.
- Same window, tx_data_rdy_i held 0 for 5 cycles on beat 2 → tx_data_o=8'h00 stays stable with valid=1; no beat skipped or repeated.
- Window x 10..5 → win_err_o single pulse, busy_o stays 0, no vld asserted.
- auto_refresh_en_i=1, period=200, window 0..3 x 0..3 → first frame starts at cycle 199 and counts 32 bytes. A tick arriving while busy runs back-to-back as pending; a third tick during that frame is dropped.
- pxl_vld_i toggling 1010 with pxl_rdy_i=1 → only the 32 handshake cycles count. pxl_stream_en_o falls the cycle after the 32nd handshake.
- rst during RA_DATA beat 1 → next cycle all outputs are 0 and state is IDLE. A new frame_start_i then completes normally.
